// File: rtl/l1_mem_arbiter_pkg.sv
// Shared types and constants for the L1 read arbiter: FSM state and owner encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package l1_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } rd_state_t;

    localparam logic OWN_IL1 = 1'b0;
    localparam logic OWN_DL1 = 1'b1;

    // Round-robin pick: a lone requester wins; on a tie the master that
    // did not complete the previous burst wins.
    function automatic logic pick_owner(input logic il1_req,
                                        input logic dl1_req,
                                        input logic last_owner);
        logic win;
        if (il1_req && dl1_req) begin
            win = ~last_owner;
        end else if (dl1_req) begin
            win = OWN_DL1;
        end else begin
            win = OWN_IL1;
        end
        return win;
    endfunction

endpackage

// File: rtl/l1_mem_arbiter_flops.sv
// Generic flop primitives: gen_dffr (plain) and gen_rsffr (load-enabled), async active-low reset.
// Latency: 1 cycle d->q.
// Backpressure: n/a; gen_rsffr holds its value while en is low.
module gen_dffr #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

module gen_rsffr #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares one memory AXI port between IL1 and DL1: round-robin read arbitration, one read outstanding; DL1 writes pass through.
// Latency: grant 1 cycle after ARVALID in IDLE; R channel and write channels are combinational (0 cycles).
// Backpressure: owner RREADY drives MEM_RREADY directly; non-owner ARREADY held low until granted; writes carry ready/valid 1:1.
// Ports: IL1_AR*/R* and DL1_AR*/R* from the caches, DL1_AW*/W*/B* write path, MEM_* toward L2/interconnect.
module l1_mem_arbiter
    import l1_mem_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic            CLK,
    input  logic            RSTn,
    // IL1 read
    input  logic [AW-1:0]   IL1_ARADDR,
    input  logic [7:0]      IL1_ARLEN,
    input  logic [1:0]      IL1_ARBURST,
    input  logic            IL1_ARVALID,
    output logic            IL1_ARREADY,
    output logic [DW-1:0]   IL1_RDATA,
    output logic [1:0]      IL1_RRESP,
    output logic            IL1_RLAST,
    output logic            IL1_RVALID,
    input  logic            IL1_RREADY,
    // DL1 read
    input  logic [AW-1:0]   DL1_ARADDR,
    input  logic [7:0]      DL1_ARLEN,
    input  logic [1:0]      DL1_ARBURST,
    input  logic            DL1_ARVALID,
    output logic            DL1_ARREADY,
    output logic [DW-1:0]   DL1_RDATA,
    output logic [1:0]      DL1_RRESP,
    output logic            DL1_RLAST,
    output logic            DL1_RVALID,
    input  logic            DL1_RREADY,
    // DL1 write
    input  logic [AW-1:0]   DL1_AWADDR,
    input  logic [7:0]      DL1_AWLEN,
    input  logic [1:0]      DL1_AWBURST,
    input  logic            DL1_AWVALID,
    output logic            DL1_AWREADY,
    input  logic [DW-1:0]   DL1_WDATA,
    input  logic [DW/8-1:0] DL1_WSTRB,
    input  logic            DL1_WLAST,
    input  logic            DL1_WVALID,
    output logic            DL1_WREADY,
    output logic [1:0]      DL1_BRESP,
    output logic            DL1_BVALID,
    input  logic            DL1_BREADY,
    // Memory side read
    output logic [AW-1:0]   MEM_ARADDR,
    output logic [7:0]      MEM_ARLEN,
    output logic [1:0]      MEM_ARBURST,
    output logic            MEM_ARVALID,
    input  logic            MEM_ARREADY,
    input  logic [DW-1:0]   MEM_RDATA,
    input  logic [1:0]      MEM_RRESP,
    input  logic            MEM_RLAST,
    input  logic            MEM_RVALID,
    output logic            MEM_RREADY,
    // Memory side write
    output logic [AW-1:0]   MEM_AWADDR,
    output logic [7:0]      MEM_AWLEN,
    output logic [1:0]      MEM_AWBURST,
    output logic            MEM_AWVALID,
    input  logic            MEM_AWREADY,
    output logic [DW-1:0]   MEM_WDATA,
    output logic [DW/8-1:0] MEM_WSTRB,
    output logic            MEM_WLAST,
    output logic            MEM_WVALID,
    input  logic            MEM_WREADY,
    input  logic [1:0]      MEM_BRESP,
    input  logic            MEM_BVALID,
    output logic            MEM_BREADY
);

    logic [1:0] state_raw;
    logic [1:0] state_nxt_raw;
    rd_state_t  state;
    rd_state_t  state_nxt;
    logic       owner;
    logic       owner_nxt;
    logic       owner_en;
    logic       last;
    logic       last_en;
    logic       ar_hs;
    logic       r_done;

    // ---------------- state register ----------------
    gen_dffr #(.W(2), .RST_VAL(2'(IDLE))) u_state (
        .clk(CLK), .rst_n(RSTn), .d(state_nxt_raw), .q(state_raw)
    );

    gen_rsffr #(.W(1), .RST_VAL(OWN_IL1)) u_owner (
        .clk(CLK), .rst_n(RSTn), .en(owner_en), .d(owner_nxt), .q(owner)
    );

    // last is only updated when a burst retires, so it always names the
    // master that most recently finished.
    gen_rsffr #(.W(1), .RST_VAL(OWN_IL1)) u_last (
        .clk(CLK), .rst_n(RSTn), .en(last_en), .d(owner), .q(last)
    );

    assign state         = rd_state_t'(state_raw);
    assign state_nxt_raw = 2'(state_nxt);

    assign ar_hs  = MEM_ARVALID & MEM_ARREADY;
    assign r_done = MEM_RVALID & MEM_RREADY & MEM_RLAST;

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        owner_nxt = pick_owner(IL1_ARVALID, DL1_ARVALID, last);
        owner_en  = 1'b0;
        last_en   = 1'b0;
        case (state)
            IDLE: begin
                if (IL1_ARVALID || DL1_ARVALID) begin
                    state_nxt = ADDR;
                    owner_en  = 1'b1;
                end
            end
            // Stays here even if the owner drops ARVALID: masters are
            // required to hold AR until accepted.
            ADDR: begin
                if (ar_hs) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (r_done) begin
                    state_nxt = IDLE;
                    last_en   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        MEM_ARADDR  = (owner == OWN_DL1) ? DL1_ARADDR  : IL1_ARADDR;
        MEM_ARLEN   = (owner == OWN_DL1) ? DL1_ARLEN   : IL1_ARLEN;
        MEM_ARBURST = (owner == OWN_DL1) ? DL1_ARBURST : IL1_ARBURST;
        MEM_ARVALID = 1'b0;
        IL1_ARREADY = 1'b0;
        DL1_ARREADY = 1'b0;
        MEM_RREADY  = 1'b0;
        IL1_RVALID  = 1'b0;
        DL1_RVALID  = 1'b0;
        case (state)
            ADDR: begin
                if (owner == OWN_DL1) begin
                    MEM_ARVALID = DL1_ARVALID;
                    DL1_ARREADY = MEM_ARREADY;
                end else begin
                    MEM_ARVALID = IL1_ARVALID;
                    IL1_ARREADY = MEM_ARREADY;
                end
            end
            DATA: begin
                if (owner == OWN_DL1) begin
                    MEM_RREADY = DL1_RREADY;
                    DL1_RVALID = MEM_RVALID;
                end else begin
                    MEM_RREADY = IL1_RREADY;
                    IL1_RVALID = MEM_RVALID;
                end
            end
            default: ;
        endcase
    end

    // R payload is broadcast; only RVALID qualifies the receiver.
    assign IL1_RDATA = MEM_RDATA;
    assign IL1_RRESP = MEM_RRESP;
    assign IL1_RLAST = MEM_RLAST;
    assign DL1_RDATA = MEM_RDATA;
    assign DL1_RRESP = MEM_RRESP;
    assign DL1_RLAST = MEM_RLAST;

    // DL1 is the only writer, so the write channels are plain wires.
    assign MEM_AWADDR  = DL1_AWADDR;
    assign MEM_AWLEN   = DL1_AWLEN;
    assign MEM_AWBURST = DL1_AWBURST;
    assign MEM_AWVALID = DL1_AWVALID;
    assign DL1_AWREADY = MEM_AWREADY;
    assign MEM_WDATA   = DL1_WDATA;
    assign MEM_WSTRB   = DL1_WSTRB;
    assign MEM_WLAST   = DL1_WLAST;
    assign MEM_WVALID  = DL1_WVALID;
    assign DL1_WREADY  = MEM_WREADY;
    assign DL1_BRESP   = MEM_BRESP;
    assign DL1_BVALID  = MEM_BVALID;
    assign MEM_BREADY  = DL1_BREADY;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Scoreboard bench for l1_mem_arbiter: directed read/write traffic with a simple memory responder.
// Latency: n/a.
// Backpressure: exercised via DL1_RREADY stalls.
module tb_l1_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;

    logic CLK = 1'b0;
    logic RSTn;
    logic [AW-1:0] IL1_ARADDR, DL1_ARADDR, MEM_ARADDR;
    logic [7:0] IL1_ARLEN, DL1_ARLEN, MEM_ARLEN;
    logic [1:0] IL1_ARBURST, DL1_ARBURST, MEM_ARBURST;
    logic IL1_ARVALID, IL1_ARREADY, DL1_ARVALID, DL1_ARREADY, MEM_ARVALID, MEM_ARREADY;
    logic [DW-1:0] IL1_RDATA, DL1_RDATA, MEM_RDATA;
    logic [1:0] IL1_RRESP, DL1_RRESP, MEM_RRESP;
    logic IL1_RLAST, DL1_RLAST, MEM_RLAST;
    logic IL1_RVALID, DL1_RVALID, MEM_RVALID;
    logic IL1_RREADY, DL1_RREADY, MEM_RREADY;
    logic [AW-1:0] DL1_AWADDR, MEM_AWADDR;
    logic [7:0] DL1_AWLEN, MEM_AWLEN;
    logic [1:0] DL1_AWBURST, MEM_AWBURST;
    logic DL1_AWVALID, MEM_AWVALID, DL1_AWREADY, MEM_AWREADY;
    logic [DW-1:0] DL1_WDATA, MEM_WDATA;
    logic [DW/8-1:0] DL1_WSTRB, MEM_WSTRB;
    logic DL1_WLAST, MEM_WLAST, DL1_WVALID, MEM_WVALID, DL1_WREADY, MEM_WREADY;
    logic [1:0] DL1_BRESP, MEM_BRESP;
    logic DL1_BVALID, MEM_BVALID, DL1_BREADY, MEM_BREADY;

    l1_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .IL1_ARADDR(IL1_ARADDR), .IL1_ARLEN(IL1_ARLEN), .IL1_ARBURST(IL1_ARBURST),
        .IL1_ARVALID(IL1_ARVALID), .IL1_ARREADY(IL1_ARREADY),
        .IL1_RDATA(IL1_RDATA), .IL1_RRESP(IL1_RRESP), .IL1_RLAST(IL1_RLAST),
        .IL1_RVALID(IL1_RVALID), .IL1_RREADY(IL1_RREADY),
        .DL1_ARADDR(DL1_ARADDR), .DL1_ARLEN(DL1_ARLEN), .DL1_ARBURST(DL1_ARBURST),
        .DL1_ARVALID(DL1_ARVALID), .DL1_ARREADY(DL1_ARREADY),
        .DL1_RDATA(DL1_RDATA), .DL1_RRESP(DL1_RRESP), .DL1_RLAST(DL1_RLAST),
        .DL1_RVALID(DL1_RVALID), .DL1_RREADY(DL1_RREADY),
        .DL1_AWADDR(DL1_AWADDR), .DL1_AWLEN(DL1_AWLEN), .DL1_AWBURST(DL1_AWBURST),
        .DL1_AWVALID(DL1_AWVALID), .DL1_AWREADY(DL1_AWREADY),
        .DL1_WDATA(DL1_WDATA), .DL1_WSTRB(DL1_WSTRB), .DL1_WLAST(DL1_WLAST),
        .DL1_WVALID(DL1_WVALID), .DL1_WREADY(DL1_WREADY),
        .DL1_BRESP(DL1_BRESP), .DL1_BVALID(DL1_BVALID), .DL1_BREADY(DL1_BREADY),
        .MEM_ARADDR(MEM_ARADDR), .MEM_ARLEN(MEM_ARLEN), .MEM_ARBURST(MEM_ARBURST),
        .MEM_ARVALID(MEM_ARVALID), .MEM_ARREADY(MEM_ARREADY),
        .MEM_RDATA(MEM_RDATA), .MEM_RRESP(MEM_RRESP), .MEM_RLAST(MEM_RLAST),
        .MEM_RVALID(MEM_RVALID), .MEM_RREADY(MEM_RREADY),
        .MEM_AWADDR(MEM_AWADDR), .MEM_AWLEN(MEM_AWLEN), .MEM_AWBURST(MEM_AWBURST),
        .MEM_AWVALID(MEM_AWVALID), .MEM_AWREADY(MEM_AWREADY),
        .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB), .MEM_WLAST(MEM_WLAST),
        .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY),
        .MEM_BRESP(MEM_BRESP), .MEM_BVALID(MEM_BVALID), .MEM_BREADY(MEM_BREADY)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] addr; logic [7:0] len; logic [1:0] burst; } ar_t;
    typedef struct { logic [63:0] data; logic last; } beat_t;

    ar_t   exp_ar[$];
    beat_t exp_il1[$];
    beat_t exp_dl1[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int ar_hs_cyc = 0;
    int il1_req_cyc = 0;
    int dl1_req_cyc = 0;
    int il1_ardy_cyc = -1;
    int dl1_last_cyc = 0;
    int il1_beats = 0;
    int dl1_beats = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    function automatic logic [63:0] bdat(input logic [31:0] a, input logic [7:0] i);
        return {~a, a + 32'(i) * 32'd8};
    endfunction

    function automatic void expect_read(input bit m, input logic [31:0] a, input logic [7:0] l);
        ar_t r;
        beat_t b;
        r.addr = a; r.len = l; r.burst = 2'b01;
        exp_ar.push_back(r);
        for (int i = 0; i <= int'(l); i++) begin
            b.data = bdat(a, 8'(i));
            b.last = (i == int'(l));
            if (m) exp_dl1.push_back(b); else exp_il1.push_back(b);
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 after the AR handshake.
    task automatic issue(input bit m, input logic [31:0] a, input logic [7:0] l);
        bit hs = 1'b0;
        if (m) begin
            DL1_ARADDR = a; DL1_ARLEN = l; DL1_ARBURST = 2'b01; DL1_ARVALID = 1'b1;
            dl1_req_cyc = cyc;
        end else begin
            IL1_ARADDR = a; IL1_ARLEN = l; IL1_ARBURST = 2'b01; IL1_ARVALID = 1'b1;
            il1_req_cyc = cyc;
        end
        for (int i = 0; i < 400 && !hs; i++) begin
            @(negedge CLK);
            hs = m ? (DL1_ARVALID && DL1_ARREADY) : (IL1_ARVALID && IL1_ARREADY);
            @(posedge CLK); #1;
        end
        if (!hs) flag(m ? "dl1_ar_timeout" : "il1_ar_timeout");
        if (m) DL1_ARVALID = 1'b0; else IL1_ARVALID = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_ar.size() + exp_il1.size() + exp_dl1.size()) != 0 && n < 1000) begin
            @(posedge CLK); #1;
            n++;
        end
        chk(name, 64'(exp_ar.size() + exp_il1.size() + exp_dl1.size()), 64'd0);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    // Memory responder: accepts one AR, then returns len+1 beats.
    initial begin
        bit ar_hs, r_hs, busy;
        logic [31:0] s_addr, a;
        logic [7:0] s_len, s_beat, l;
        busy = 1'b0; s_addr = '0; s_len = '0; s_beat = '0;
        MEM_ARREADY = 1'b0; MEM_RVALID = 1'b0; MEM_RDATA = '0; MEM_RRESP = 2'b00; MEM_RLAST = 1'b0;
        forever begin
            @(negedge CLK);
            ar_hs = MEM_ARVALID && MEM_ARREADY;
            r_hs  = MEM_RVALID && MEM_RREADY;
            a = MEM_ARADDR; l = MEM_ARLEN;
            @(posedge CLK); #1;
            if (!RSTn) begin
                busy = 1'b0;
            end else begin
                if (r_hs) begin
                    if (s_beat == s_len) busy = 1'b0;
                    else s_beat = s_beat + 8'd1;
                end
                if (ar_hs) begin
                    busy = 1'b1; s_addr = a; s_len = l; s_beat = '0;
                end
            end
            MEM_ARREADY = !busy;
            MEM_RVALID  = busy;
            MEM_RDATA   = bdat(s_addr, s_beat);
            MEM_RLAST   = (s_beat == s_len);
        end
    end

    // Scoreboard monitor.
    always @(negedge CLK) begin
        ar_t e;
        beat_t b;
        if (IL1_ARREADY && il1_ardy_cyc < 0) il1_ardy_cyc = cyc;
        if (MEM_ARVALID && MEM_ARREADY) begin
            ar_hs_cyc = cyc;
            if (exp_ar.size() == 0) flag("mem_ar_unexpected");
            else begin
                e = exp_ar.pop_front();
                chk("mem_araddr", 64'(MEM_ARADDR), 64'(e.addr));
                chk("mem_arlen", 64'(MEM_ARLEN), 64'(e.len));
                chk("mem_arburst", 64'(MEM_ARBURST), 64'(e.burst));
            end
        end
        if (IL1_RVALID && IL1_RREADY) begin
            il1_beats++;
            chk("il1_excl", 64'(DL1_RVALID), 64'd0);
            if (exp_il1.size() == 0) flag("il1_beat_unexpected");
            else begin
                b = exp_il1.pop_front();
                chk("il1_rdata", IL1_RDATA, b.data);
                chk("il1_rlast", 64'(IL1_RLAST), 64'(b.last));
            end
        end
        if (DL1_RVALID && DL1_RREADY) begin
            dl1_beats++;
            if (DL1_RLAST) dl1_last_cyc = cyc;
            chk("dl1_excl", 64'(IL1_RVALID), 64'd0);
            if (exp_dl1.size() == 0) flag("dl1_beat_unexpected");
            else begin
                b = exp_dl1.pop_front();
                chk("dl1_rdata", DL1_RDATA, b.data);
                chk("dl1_rlast", 64'(DL1_RLAST), 64'(b.last));
            end
        end
    end

    task automatic wait_dl1_beats(input int target);
        int n = 0;
        while (dl1_beats < target && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        if (dl1_beats < target) flag("dl1_beat_wait_timeout");
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_il1_arready"}, 64'(IL1_ARREADY), 64'd0);
        chk({tag, "_dl1_arready"}, 64'(DL1_ARREADY), 64'd0);
        chk({tag, "_il1_rvalid"}, 64'(IL1_RVALID), 64'd0);
        chk({tag, "_dl1_rvalid"}, 64'(DL1_RVALID), 64'd0);
        chk({tag, "_mem_arvalid"}, 64'(MEM_ARVALID), 64'd0);
        chk({tag, "_mem_rready"}, 64'(MEM_RREADY), 64'd0);
    endtask

    initial begin
        int start, istart;
        RSTn = 1'b0;
        IL1_ARADDR = '0; IL1_ARLEN = '0; IL1_ARBURST = '0; IL1_ARVALID = 1'b0; IL1_RREADY = 1'b1;
        DL1_ARADDR = '0; DL1_ARLEN = '0; DL1_ARBURST = '0; DL1_ARVALID = 1'b0; DL1_RREADY = 1'b1;
        DL1_AWADDR = 32'h1234_5678; DL1_AWLEN = 8'h3; DL1_AWBURST = 2'b01; DL1_AWVALID = 1'b1;
        DL1_WDATA = 64'hDEAD_BEEF_0BAD_F00D; DL1_WSTRB = 8'hF0; DL1_WLAST = 1'b1; DL1_WVALID = 1'b1;
        DL1_BREADY = 1'b1; MEM_AWREADY = 1'b1; MEM_WREADY = 1'b0; MEM_BRESP = 2'b10; MEM_BVALID = 1'b1;

        // Reset state.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_idle_outputs("reset");
        chk("reset_aw_pass", 64'({MEM_AWADDR, MEM_AWLEN, MEM_AWBURST, MEM_AWVALID}),
            64'({32'h1234_5678, 8'h3, 2'b01, 1'b1}));
        chk("reset_b_pass", 64'({DL1_AWREADY, DL1_WREADY, DL1_BRESP, DL1_BVALID, MEM_BREADY}),
            64'({1'b1, 1'b0, 2'b10, 1'b1, 1'b1}));
        @(posedge CLK); #1;
        RSTn = 1'b1;
        DL1_AWVALID = 1'b0; DL1_WVALID = 1'b0; MEM_BVALID = 1'b0;
        @(posedge CLK); #1;

        // Simultaneous after reset: DL1 wins the first tie.
        expect_read(1'b1, 32'h2000, 8'd3);
        expect_read(1'b0, 32'h1000, 8'd1);
        il1_ardy_cyc = -1;
        fork
            issue(1'b0, 32'h1000, 8'd1);
            issue(1'b1, 32'h2000, 8'd3);
        join
        drain("simul_drain");
        chk("simul_turnaround", 64'(il1_ardy_cyc - dl1_last_cyc), 64'd2);

        // Sustained contention: strict D,I alternation.
        for (int k = 0; k < 6; k++) begin
            expect_read(1'b1, 32'h5000 + 32'(k) * 32'h100, 8'(k % 4));
            expect_read(1'b0, 32'h6000 + 32'(k) * 32'h100, 8'(k % 4));
        end
        fork
            begin
                for (int k = 0; k < 6; k++) issue(1'b1, 32'h5000 + 32'(k) * 32'h100, 8'(k % 4));
            end
            begin
                for (int j = 0; j < 6; j++) issue(1'b0, 32'h6000 + 32'(j) * 32'h100, 8'(j % 4));
            end
        join
        drain("contention_drain");

        // Lone DL1 read.
        start = dl1_beats; istart = il1_beats;
        expect_read(1'b1, 32'h8000_0040, 8'd3);
        issue(1'b1, 32'h8000_0040, 8'd3);
        chk("lone_grant_latency", 64'(ar_hs_cyc - dl1_req_cyc), 64'd1);
        drain("lone_drain");
        chk("lone_dl1_beats", 64'(dl1_beats - start), 64'd4);
        chk("lone_il1_beats", 64'(il1_beats - istart), 64'd0);

        // Backpressure: DL1 stalls RREADY for 3 cycles mid-burst.
        start = dl1_beats;
        expect_read(1'b1, 32'h9000, 8'd7);
        issue(1'b1, 32'h9000, 8'd7);
        wait_dl1_beats(start + 3);
        DL1_RREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("bp_mem_rready", 64'(MEM_RREADY), 64'd0);
            @(posedge CLK); #1;
        end
        DL1_RREADY = 1'b1;
        drain("bp_drain");
        chk("bp_dl1_beats", 64'(dl1_beats - start), 64'd8);

        // Write passthrough while IL1 owns the read path.
        istart = il1_beats;
        expect_read(1'b0, 32'h3000, 8'd7);
        issue(1'b0, 32'h3000, 8'd7);
        for (int i = 0; i < 6; i++) begin
            logic [2:0] iv;
            iv = 3'(i);
            DL1_AWADDR = 32'h4000_0000 + 32'(i) * 32'd64; DL1_AWLEN = 8'(i); DL1_AWBURST = iv[1:0];
            DL1_AWVALID = iv[0]; DL1_WDATA = {32'hA5A5_0000 | 32'(i), ~32'(i)};
            DL1_WSTRB = 8'hFF >> i; DL1_WLAST = (i == 5); DL1_WVALID = !iv[0]; DL1_BREADY = iv[1];
            MEM_AWREADY = iv[1]; MEM_WREADY = iv[0]; MEM_BRESP = iv[1:0]; MEM_BVALID = (i > 2);
            @(negedge CLK);
            chk("wr_aw_pass", 64'({MEM_AWADDR, MEM_AWLEN, MEM_AWBURST, MEM_AWVALID}),
                64'({32'h4000_0000 + 32'(i) * 32'd64, 8'(i), iv[1:0], iv[0]}));
            chk("wr_wdata_pass", MEM_WDATA, {32'hA5A5_0000 | 32'(i), ~32'(i)});
            chk("wr_wctl_pass", 64'({MEM_WSTRB, MEM_WLAST, MEM_WVALID}),
                64'({8'hFF >> i, (i == 5), !iv[0]}));
            chk("wr_b_pass", 64'({DL1_AWREADY, DL1_WREADY, DL1_BRESP, DL1_BVALID, MEM_BREADY}),
                64'({iv[1], iv[0], iv[1:0], (i > 2), iv[1]}));
            @(posedge CLK); #1;
        end
        DL1_AWVALID = 1'b0; DL1_WVALID = 1'b0; MEM_BVALID = 1'b0;
        drain("wr_read_drain");
        chk("wr_il1_beats", 64'(il1_beats - istart), 64'd8);

        // Reset in the middle of a DL1 burst.
        start = dl1_beats;
        expect_read(1'b1, 32'hA000, 8'd3);
        issue(1'b1, 32'hA000, 8'd3);
        wait_dl1_beats(start + 2);
        #1;
        RSTn = 1'b0;
        @(negedge CLK);
        check_idle_outputs("midrst");
        chk("midrst_beats_left", 64'(exp_dl1.size()), 64'd2);
        exp_dl1.delete();
        exp_ar.delete();
        @(posedge CLK); #2;
        RSTn = 1'b1;
        @(posedge CLK); #1;

        // Post-reset IL1 single-beat read is granted normally.
        istart = il1_beats;
        expect_read(1'b0, 32'h7000, 8'd0);
        issue(1'b0, 32'h7000, 8'd0);
        chk("postrst_grant_latency", 64'(ar_hs_cyc - il1_req_cyc), 64'd1);
        drain("postrst_drain");
        chk("postrst_il1_beats", 64'(il1_beats - istart), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/l1_mem_arbiter.md
# l1_mem_arbiter

Shares the single memory-side AXI port between the L1 instruction cache (IL1) and the L1 data cache (DL1). Read bursts (address plus data) are arbitrated round-robin, with at most one read outstanding. DL1 write channels pass straight through, because DL1 is the only writer. The block sits between the two L1 caches and the L2/memory interconnect.

## Interface
Parameters:
- AW, 32, address width
- DW, 64, data width of the R/W channels

Ports:
- CLK  in  1  clock, single clock domain
- RSTn  in  1  asynchronous, active-low reset
- IL1_ARADDR/ARLEN/ARBURST/ARVALID  in  AW/8/2/1  IL1 read request
- IL1_ARREADY  out  1
- IL1_RDATA/RRESP/RLAST/RVALID  out  DW/2/1/1  IL1 read data
- IL1_RREADY  in  1
- DL1_ARADDR/ARLEN/ARBURST/ARVALID  in  AW/8/2/1  DL1 read request
- DL1_ARREADY  out  1
- DL1_RDATA/RRESP/RLAST/RVALID  out  DW/2/1/1  DL1 read data
- DL1_RREADY  in  1
- DL1_AW*/W*/B*  mixed  AW…DW  DL1 write channels, forwarded 1:1 to/from MEM_AW*/W*/B*
- MEM_ARADDR/ARLEN/ARBURST/ARVALID  out  AW/8/2/1  arbitrated read request
- MEM_ARREADY  in  1
- MEM_RDATA/RRESP/RLAST/RVALID  in  DW/2/1/1
- MEM_RREADY  out  1

## Operation
- Read FSM states:
  - IDLE: no grant.
  - ADDR: the grant owner's AR is forwarded to MEM.
  - DATA: R beats are routed to the owner.
- Registers:
  - owner: 0 = IL1, 1 = DL1.
  - last: owner of the most recently completed burst.
- IDLE transition:
  - If any ARVALID is high, go to ADDR and register owner.
  - With a single requester, that requester wins.
  - With both requesting, the master other than last wins. last resets to IL1, so DL1 wins the first tie.
- ADDR state:
  - MEM_AR* = owner's AR* fields.
  - MEM_ARVALID = owner's ARVALID.
  - Owner's ARREADY = MEM_ARREADY. The non-owner's ARREADY = 0.
  - On the MEM AR handshake, go to DATA.
- DATA state:
  - RDATA/RRESP/RLAST are broadcast to both masters.
  - Only the owner sees RVALID = MEM_RVALID.
  - MEM_RREADY = owner's RREADY.
  - On a beat with MEM_RVALID & MEM_RREADY & MEM_RLAST: go to IDLE and set last := owner.
- Outside DATA:
  - MEM_RREADY = 0, and both IL1_RVALID and DL1_RVALID = 0.
  - Stray beats stay stalled at MEM.
- Masters must hold AR stable until ARREADY. If ARVALID drops during ADDR, the FSM remains in ADDR; no timeout.
- The write path is purely combinational with no state, and is independent of read state.
- Read/write ordering is DL1's responsibility.

## Timing
- Reset values:
  - State IDLE, owner IL1, last IL1.
  - All *ARREADY, *RVALID, MEM_ARVALID and MEM_RREADY are 0.
  - Write outputs follow their inputs.
- Arbitration latency: ARVALID seen in IDLE at cycle N → MEM_ARVALID high at cycle N+1.
- Read channels add no latency in DATA: R is combinational from MEM to the owner.
- Turnaround: the RLAST handshake at cycle M puts the FSM in IDLE at M+1. A pending request is granted with MEM_ARVALID at M+2.
- A request arriving while the FSM is in ADDR or DATA waits; its ARREADY stays 0.
- Back-to-back requests from both masters alternate strictly: DL1, IL1, DL1, ….
- Asynchronous reset mid-burst immediately returns the FSM to IDLE and drops all grant-gated outputs. Any in-flight MEM burst is abandoned; the interconnect is reset together with the caches.
- ARLEN of 0 (single beat) is legal: the first beat carries RLAST.

## Structure
- Shared package constants: state encodings (IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2) and owner encodings (OWN_IL1 = 1'b0, OWN_DL1 = 1'b1).
- State, owner and last are built from the existing gen_dffr/gen_rsffr flop primitives.
- No further sub-module is needed.
- The 2-way mux is written inline.

## Test plan
- **Lone DL1 read:** ARADDR=0x8000_0040, ARLEN=3 → MEM_ARVALID one cycle later with the same address; exactly 4 beats reach DL1; IL1_RVALID stays 0 throughout.
- **Simultaneous after reset:** both ARVALID high (IL1 0x1000, DL1 0x2000) → MEM sees 0x2000 first, then 0x1000. IL1_ARREADY is first asserted only after DL1's RLAST handshake plus 2 cycles.
- **Sustained contention:** both keep requesting 6 bursts each → MEM AR order is D,I,D,I,…; no starvation.
- **Backpressure:** owner drops RREADY for 3 cycles mid-burst → MEM_RREADY low for those cycles; no beat lost or duplicated; RDATA sequence intact.
- **Reset mid-DATA:** RSTn low after beat 2 of 4 → next cycle all RVALID/ARREADY/MEM_ARVALID = 0 and the FSM is in IDLE. After release, a new IL1 request is granted normally.
- **Write passthrough during read:** DL1 AW/W/B traffic runs while IL1 owns the read path → MEM_AW*/W* mirror the DL1 inputs each cycle; DL1_B* mirror MEM_B*; the IL1 read is unaffected.
